// File: rtl/demux14_pkg.sv
// Shared definitions for the demux14_buf 1-to-4 registered demultiplexer.
package demux14_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  // Occupancy of one output slot.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Bit offset of channel `ch` inside a packed bus of `width`-bit words.
  function automatic int slice_off(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/demux14_slot.sv
// One-entry output register slice for demux14_buf. It supports three
// operations: load when empty, drain when full, and reload (drain and load
// in the same cycle) with no bubble.
module demux14_slot
  import demux14_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  drain,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  slot_state_e state;

  // Slot FSM: track occupancy and capture incoming words.
  // NOTE: the data register is reset as well because consumers
  // see out_data directly. Non-blocking assignments keep every flop in
  // this block updating from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state    <= FULL;
            out_data <= in_data;
          end
        end
        FULL: begin
          if (drain) begin
            if (load) begin
              out_data <= in_data;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: rtl/demux14_buf.sv
// demux14_buf: 1-to-4 registered demultiplexer with valid/ready handshake.
// It fans out one producer to four independently stalling consumers.
// Optional per-channel accept counters are enabled with DEMUX14_STATS_EN.
module demux14_buf
  import demux14_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]              in_sel,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready
`ifdef DEMUX14_STATS_EN
  ,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT*CNT_WIDTH-1:0]  xfer_cnt
`else
  ,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data
`endif
);

  logic               accept;
  logic [NUM_OUT-1:0] load;

  // The selected slot can take a word if it is empty or drains this cycle.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  // Decode the accepted word into a one-hot load for the target slot.
  // NOTE: default first, so every path assigns load and no latch is inferred.
  always_comb begin
    load         = '0;
    load[in_sel] = accept;
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    demux14_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .in_data   (in_data),
      .drain     (out_ready[i]),
      .out_valid (out_valid[i]),
      .out_data  (out_data[slice_off(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

`ifdef DEMUX14_STATS_EN
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
    // Count accepts per channel. Wrap silently at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        xfer_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= '0;
      end else if (load[i]) begin
        xfer_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= xfer_cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux14_buf.sv
// Directed self-checking bench for demux14_buf. Inputs change just after
// the falling edge. Outputs are sampled at the falling edge, or 1 time unit
// after an input change when checking in_ready.
module tb_demux14_buf;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [4*DW-1:0] out_data;
`ifdef DEMUX14_STATS_EN
  logic [4*CW-1:0] xfer_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  demux14_buf #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX14_STATS_EN
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
`else
    .out_data  (out_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] ch(input int i);
    return out_data[i*DW +: DW];
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    out_ready = 4'b0000;

    // Reset for 3 cycles, then release.
    step(); step(); step();
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_out_valid", 128'(out_valid), 128'(4'b0000));
    rst_n = 1'b1;
    step();
    check("idle_out_valid", 128'(out_valid), 128'(4'b0000));
    check("idle_out_data", 128'(out_data), 128'(0));
    check("idle_in_ready", 128'(in_ready), 128'(1'b1));
`ifdef DEMUX14_STATS_EN
    check("idle_xfer_cnt", 128'(xfer_cnt), 128'(0));
`endif

    // Route one word to each channel with all consumers ready.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      in_data  = 32'hA0 + 32'(i);
      #1;
      check($sformatf("route_in_ready%0d", i), 128'(in_ready), 128'(1'b1));
      step();
      check($sformatf("route_valid%0d", i), 128'(out_valid), 128'(4'b0001 << i));
      check($sformatf("route_data%0d", i), 128'(ch(i)), 128'(32'hA0 + 32'(i)));
    end
    in_valid = 1'b0;
    step();
    check("route_drained", 128'(out_valid), 128'(4'b0000));

    // Stall isolation on channel 2.
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    in_data   = 32'h11;
    step();
    check("stall_valid_11", 128'(out_valid), 128'(4'b0100));
    check("stall_data_11", 128'(ch(2)), 128'(32'h11));
    in_data = 32'h22;
    #1;
    check("stall_in_ready_22", 128'(in_ready), 128'(1'b0));
    // Another channel stays open while channel 2 is stalled.
    in_valid = 1'b0;
    in_sel   = 2'd1;
    #1;
    check("stall_ch1_open", 128'(in_ready), 128'(1'b1));
    in_sel   = 2'd2;
    in_valid = 1'b1;
    step();
    check("stall_hold_valid", 128'(out_valid), 128'(4'b0100));
    check("stall_hold_data", 128'(ch(2)), 128'(32'h11));
    check("stall_still_blocked", 128'(in_ready), 128'(1'b0));
    out_ready = 4'b1111;
    #1;
    check("reload_in_ready", 128'(in_ready), 128'(1'b1));
    step();
    check("reload_valid", 128'(out_valid), 128'(4'b0100));
    check("reload_data", 128'(ch(2)), 128'(32'h22));
    in_sel  = 2'd1;
    in_data = 32'h33;
    step();
    check("deliver33_valid", 128'(out_valid), 128'(4'b0010));
    check("deliver33_data", 128'(ch(1)), 128'(32'h33));
    in_valid = 1'b0;
    step();
    check("stall_done", 128'(out_valid), 128'(4'b0000));

    // Back-to-back streaming on channel 3.
    out_ready = 4'b1000;
    in_sel    = 2'd3;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + 32'(k);
      #1;
      check($sformatf("stream_ready%0d", k), 128'(in_ready), 128'(1'b1));
      step();
      check($sformatf("stream_valid%0d", k), 128'(out_valid), 128'(4'b1000));
      check($sformatf("stream_data%0d", k), 128'(ch(3)), 128'(32'hB0 + 32'(k)));
    end
    in_valid = 1'b0;
    step();
    check("stream_done", 128'(out_valid), 128'(4'b0000));

    // Asynchronous reset while channels 0 and 3 are full and stalled.
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 32'hC0;
    step();
    in_sel    = 2'd3;
    in_data   = 32'hC3;
    step();
    in_valid  = 1'b0;
    check("pre_rst_valid", 128'(out_valid), 128'(4'b1001));
    check("pre_rst_in_ready", 128'(in_ready), 128'(1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(4'b0000));
    check("mid_rst_data", 128'(out_data), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 128'(out_valid), 128'(4'b0000));
    check("post_rst_data", 128'(out_data), 128'(0));

    // 17 accepts to channel 1. A 4-bit counter wraps to 1.
    out_ready = 4'b1111;
    in_sel    = 2'd1;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hD00 + 32'(k);
      step();
    end
    check("wrap_last_data", 128'(ch(1)), 128'(32'hD10));
    check("wrap_last_valid", 128'(out_valid), 128'(4'b0010));
    in_valid = 1'b0;
    step();
    check("wrap_drained", 128'(out_valid), 128'(4'b0000));
`ifdef DEMUX14_STATS_EN
    check("wrap_xfer_cnt", 128'(xfer_cnt), 128'(16'h0010));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
